// File: rtl/a2d_pkg.sv
// Shared types and helpers for the ADC128S round-robin interface.
// Channel numbers, FSM states and the command-word builder live here.
package a2d_pkg;

  localparam logic [2:0] CH_LFT  = 3'd0;
  localparam logic [2:0] CH_RGHT = 3'd4;
  localparam logic [2:0] CH_BATT = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    GAP,
    READ,
    STORE
  } a2d_state_t;

  // Round-robin slot index; only 0..2 are ever used.
  typedef logic [1:0] rr_idx_t;

  localparam rr_idx_t RR_LFT  = 2'd0;
  localparam rr_idx_t RR_RGHT = 2'd1;
  localparam rr_idx_t RR_BATT = 2'd2;

  function automatic logic [15:0] cmd_word(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

  function automatic logic [2:0] idx2ch(input rr_idx_t idx);
    case (idx)
      RR_RGHT: return CH_RGHT;
      RR_BATT: return CH_BATT;
      default: return CH_LFT;
    endcase
  endfunction

  function automatic rr_idx_t rr_next(input rr_idx_t idx);
    return (idx == RR_BATT) ? RR_LFT : idx + 2'd1;
  endfunction

endpackage

// File: rtl/a2d_intf_spi_mstr16.sv
// 16-bit SPI master, SCLK idles high, data launched on fall and sampled on rise.
// One shift register carries MOSI out and MISO in; rd_data holds until the next wrt.
module spi_mstr16 #(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic        done,
  output logic [15:0] rd_data
);

  // Idle count sits 8 ticks before the first fall, giving a front porch.
  localparam logic [SCLK_DIV_W-1:0] CNT_IDLE = {2'b10, {(SCLK_DIV_W-2){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] CNT_FALL = {SCLK_DIV_W{1'b1}};
  localparam logic [SCLK_DIV_W-1:0] CNT_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
  localparam logic [SCLK_DIV_W-1:0] CNT_ONE  = {{(SCLK_DIV_W-1){1'b0}}, 1'b1};

  logic [SCLK_DIV_W-1:0] r_cnt;
  logic [15:0]           r_shft;
  logic [4:0]            r_smpl_cnt;
  logic                  r_miso;
  logic                  r_ss_n;
  logic                  r_done;

  logic w_fall;
  logic w_rise;
  logic w_last;

  assign w_fall = !r_ss_n && (r_cnt == CNT_FALL);
  assign w_rise = !r_ss_n && (r_cnt == CNT_RISE);
  assign w_last = w_fall && (r_smpl_cnt == 5'd16);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= CNT_IDLE;
      r_shft     <= '0;
      r_smpl_cnt <= '0;
      r_miso     <= 1'b0;
      r_ss_n     <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_ss_n) begin
        if (wrt) begin
          r_ss_n     <= 1'b0;
          r_shft     <= cmd;
          r_cnt      <= r_cnt + CNT_ONE;
          r_smpl_cnt <= '0;
        end
      end else if (w_last) begin
        r_shft <= {r_shft[14:0], r_miso};
        r_cnt  <= CNT_IDLE;
        r_ss_n <= 1'b1;
        r_done <= 1'b1;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
        if (w_rise) begin
          r_miso     <= MISO;
          r_smpl_cnt <= r_smpl_cnt + 5'd1;
        end
        // The porch fall precedes any sample, so it must not shift.
        if (w_fall && (r_smpl_cnt != 5'd0))
          r_shft <= {r_shft[14:0], r_miso};
      end
    end
  end

  assign SS_n    = r_ss_n;
  assign SCLK    = r_cnt[SCLK_DIV_W-1];
  assign MOSI    = r_shft[15];
  assign done    = r_done;
  assign rd_data = r_shft;

endmodule

// File: rtl/a2d_intf.sv
// ADC128S front-end: round-robins channels 0, 4, 5 and registers 12-bit results.
// Each conversion is two frames since the A2D answers for the previously addressed channel.
//
// state | meaning
// IDLE  | waiting for nxt
// CMD   | first frame, addresses the channel; returned data discarded
// GAP   | one clk with SS_n high, then re-issue the same command
// READ  | second frame; result captured as done arrives
// STORE | advance round-robin pointer
module a2d_intf
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        vld
);

  a2d_state_t  r_state;
  rr_idx_t     r_ptr;
  logic [11:0] r_lft;
  logic [11:0] r_rght;
  logic [11:0] r_batt;
  logic        r_vld;

  logic        w_wrt;
  logic        w_done;
  logic [15:0] w_cmd;
  logic [15:0] w_rd_data;
  logic        w_unused;

  assign w_wrt    = ((r_state == IDLE) && nxt) || (r_state == GAP);
  assign w_cmd    = cmd_word(idx2ch(r_ptr));
  // Status nibble from the converter carries no information.
  assign w_unused = ^w_rd_data[15:12];

  spi_mstr16 #(
    .SCLK_DIV_W(SCLK_DIV_W)
  ) u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (w_wrt),
    .cmd     (w_cmd),
    .MISO    (MISO),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .done    (w_done),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= RR_LFT;
      r_lft   <= '0;
      r_rght  <= '0;
      r_batt  <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        IDLE:  if (nxt) r_state <= CMD;
        CMD:   if (w_done) r_state <= GAP;
        GAP:   r_state <= READ;
        READ: begin
          // Results and vld register on done so they appear during STORE.
          if (w_done) begin
            case (r_ptr)
              RR_LFT:  r_lft  <= w_rd_data[11:0];
              RR_RGHT: r_rght <= w_rd_data[11:0];
              RR_BATT: r_batt <= w_rd_data[11:0];
              default: ;
            endcase
            r_vld   <= 1'b1;
            r_state <= STORE;
          end
        end
        STORE: begin
          r_ptr   <= rr_next(r_ptr);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign lft_ld  = r_lft;
  assign rght_ld = r_rght;
  assign batt    = r_batt;
  assign vld     = r_vld;

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: ADC128S behavioural model on the SPI pins, MOSI-word scoreboard,
// vector table for the round-robin sequence plus busy-ignore and mid-frame reset cases.
module tb_a2d_intf;

  localparam int LAT_MAX = 2 * (16 * 32 + 8) + 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nxt = 1'b0;
  logic        MISO = 1'b0;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] batt;
  logic        vld;

  int n_tests = 0;
  int n_fail  = 0;

  a2d_intf #(.SCLK_DIV_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .nxt     (nxt),
    .MISO    (MISO),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .lft_ld  (lft_ld),
    .rght_ld (rght_ld),
    .batt    (batt),
    .vld     (vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ADC128S model: answers with the channel addressed in the previous complete frame.
  logic [11:0] ld_cell_lft = 12'h000;
  logic [11:0] ld_cell_rght = 12'h000;
  logic [11:0] batt_V = 12'h000;
  logic [2:0]  prev_ch = 3'd0;
  logic [15:0] tx;
  logic [15:0] rx;
  int          rises;
  int          bad_ch = 0;
  logic [15:0] exp_mosi[$];

  function automatic logic [11:0] adc_val(input logic [2:0] ch);
    case (ch)
      3'd0:    return ld_cell_lft;
      3'd4:    return ld_cell_rght;
      3'd5:    return batt_V;
      default: return 12'h000;
    endcase
  endfunction

  always begin
    @(negedge SS_n);
    tx    = {4'h0, adc_val(prev_ch)};
    rx    = '0;
    rises = 0;
    MISO  = tx[15];
    while (SS_n == 1'b0) begin
      @(posedge SCLK or negedge SCLK or posedge SS_n);
      if (SS_n !== 1'b0) break;
      if (SCLK) begin
        rx = {rx[14:0], MOSI};
        rises++;
      end else if (rises > 0) begin
        tx   = {tx[14:0], 1'b0};
        MISO = tx[15];
      end
    end
    if (rises == 16) begin
      if (exp_mosi.size() == 0) chk("mosi_unexpected_frame", {16'h0, rx}, 32'hFFFF_FFFF);
      else chk("mosi_word", {16'h0, rx}, {16'h0, exp_mosi.pop_front()});
      prev_ch = rx[13:11];
      if (!(prev_ch inside {3'd0, 3'd4, 3'd5})) begin
        bad_ch++;
        $display("A2D channel warning: channel %0d addressed", prev_ch);
      end
    end
  end

  // vld pulse counter and inter-frame deselect monitor
  int   vld_cnt = 0;
  int   hi_run = 0;
  logic ss_mon_prev = 1'b1;
  always @(negedge clk) begin
    if (vld === 1'b1) vld_cnt++;
    if (rst_n) begin
      if (SS_n) hi_run++;
      else begin
        if (ss_mon_prev) chk("ss_gap_ge1", 32'(hi_run >= 1), 32'd1);
        hi_run = 0;
      end
    end
    ss_mon_prev = SS_n;
  end

  task automatic run_conv(output int lat);
    lat = -1;
    nxt = 1'b1;
    for (int i = 1; i <= LAT_MAX + 20; i++) begin
      @(negedge clk);
      nxt = 1'b0;
      if (vld === 1'b1) begin
        lat = i;
        return;
      end
    end
  endtask

  typedef struct {
    logic [11:0] lft_in;
    logic [11:0] rght_in;
    logic [11:0] batt_in;
    logic [15:0] exp_cmd;
    logic [11:0] exp_lft;
    logic [11:0] exp_rght;
    logic [11:0] exp_batt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int   lat;
    int   v0;
    int   falls;
    logic ssp;

    vecs[0] = '{12'hA5C, 12'h000, 12'h000, 16'h0000, 12'hA5C, 12'h000, 12'h000};
    vecs[1] = '{12'hA5C, 12'h3C1, 12'h000, 16'h2000, 12'hA5C, 12'h3C1, 12'h000};
    vecs[2] = '{12'hA5C, 12'h3C1, 12'hD80, 16'h2800, 12'hA5C, 12'h3C1, 12'hD80};
    vecs[3] = '{12'h123, 12'h3C1, 12'hD80, 16'h0000, 12'h123, 12'h3C1, 12'hD80};
    vecs[4] = '{12'h123, 12'h0FF, 12'hD80, 16'h2000, 12'h123, 12'h0FF, 12'hD80};
    vecs[5] = '{12'h123, 12'h0FF, 12'hFFF, 16'h2800, 12'h123, 12'h0FF, 12'hFFF};

    repeat (3) @(negedge clk);
    chk("rst_SS_n", {31'h0, SS_n}, 32'd1);
    chk("rst_SCLK", {31'h0, SCLK}, 32'd1);
    chk("rst_MOSI", {31'h0, MOSI}, 32'd0);
    chk("rst_vld", {31'h0, vld}, 32'd0);
    chk("rst_results", {8'h0, lft_ld, rght_ld}, 32'd0);
    chk("rst_batt", {20'h0, batt}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      ld_cell_lft  = vecs[k].lft_in;
      ld_cell_rght = vecs[k].rght_in;
      batt_V       = vecs[k].batt_in;
      exp_mosi.push_back(vecs[k].exp_cmd);
      exp_mosi.push_back(vecs[k].exp_cmd);
      v0 = vld_cnt;
      run_conv(lat);
      chk($sformatf("v%0d_latency_ok", k), 32'(lat > 0 && lat <= LAT_MAX), 32'd1);
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d_vld_pulses", k), 32'(vld_cnt - v0), 32'd1);
      chk($sformatf("v%0d_lft", k), {20'h0, lft_ld}, {20'h0, vecs[k].exp_lft});
      chk($sformatf("v%0d_rght", k), {20'h0, rght_ld}, {20'h0, vecs[k].exp_rght});
      chk($sformatf("v%0d_batt", k), {20'h0, batt}, {20'h0, vecs[k].exp_batt});
    end

    // nxt pulses every 50 clks while busy must not queue a second conversion
    ld_cell_lft = 12'h456;
    exp_mosi.push_back(16'h0000);
    exp_mosi.push_back(16'h0000);
    v0  = vld_cnt;
    lat = -1;
    nxt = 1'b1;
    for (int i = 1; i <= LAT_MAX + 20; i++) begin
      @(negedge clk);
      if (vld === 1'b1) begin
        nxt = 1'b0;
        lat = i;
        break;
      end
      nxt = ((i % 50) == 0);
    end
    nxt = 1'b0;
    chk("busy_latency_ok", 32'(lat > 0 && lat <= LAT_MAX), 32'd1);
    repeat (100) @(negedge clk);
    chk("busy_vld_pulses", 32'(vld_cnt - v0), 32'd1);
    chk("busy_idle_after", {31'h0, SS_n}, 32'd1);
    chk("busy_lft", {20'h0, lft_ld}, 32'h456);
    chk("busy_rght_hold", {20'h0, rght_ld}, 32'h0FF);

    ld_cell_rght = 12'h2B7;
    exp_mosi.push_back(16'h2000);
    exp_mosi.push_back(16'h2000);
    run_conv(lat);
    chk("ptr_step_latency_ok", 32'(lat > 0 && lat <= LAT_MAX), 32'd1);
    repeat (4) @(negedge clk);
    chk("ptr_step_rght", {20'h0, rght_ld}, 32'h2B7);
    chk("ptr_step_lft_hold", {20'h0, lft_ld}, 32'h456);

    // reset during the low phase of the 8th SCLK of the READ frame (channel 5)
    batt_V = 12'hEEE;
    exp_mosi.push_back(16'h2800);
    exp_mosi.push_back(16'h2800);
    ssp   = SS_n;
    falls = 0;
    nxt   = 1'b1;
    for (int c = 0; c < 3000 && falls < 2; c++) begin
      @(negedge clk);
      nxt = 1'b0;
      if (ssp && !SS_n) falls++;
      ssp = SS_n;
    end
    chk("rst_frame_found", falls, 32'd2);
    repeat (236) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_SS_n", {31'h0, SS_n}, 32'd1);
    chk("midrst_SCLK", {31'h0, SCLK}, 32'd1);
    chk("midrst_lft", {20'h0, lft_ld}, 32'd0);
    chk("midrst_rght", {20'h0, rght_ld}, 32'd0);
    chk("midrst_batt", {20'h0, batt}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_mosi.delete();
    repeat (3) @(negedge clk);

    ld_cell_lft = 12'h777;
    exp_mosi.push_back(16'h0000);
    exp_mosi.push_back(16'h0000);
    run_conv(lat);
    chk("post_rst_latency_ok", 32'(lat > 0 && lat <= LAT_MAX), 32'd1);
    repeat (4) @(negedge clk);
    chk("post_rst_lft", {20'h0, lft_ld}, 32'h777);
    chk("post_rst_rght", {20'h0, rght_ld}, 32'd0);
    chk("post_rst_batt", {20'h0, batt}, 32'd0);

    chk("bad_channel_count", bad_ch, 32'd0);
    chk("scoreboard_drained", exp_mosi.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/a2d_intf.md
Name: a2d_intf

Overview:
- SPI master front-end for the ADC128S 12-bit A2D.
- Round-robins conversions over channels 0 (left load cell), 4 (right load cell) and 5 (battery) and presents registered 12-bit results to the balance controller.
- Sits directly upstream of the A2D: its SS_n/SCLK/MOSI drive the converter, and it consumes MISO.
- Each conversion takes two 16-bit SPI transactions, because the A2D returns data for the channel addressed in the previous transaction.

Parameters:
SCLK_DIV_W, 5, SCLK period = 2^SCLK_DIV_W clk cycles (default: SCLK = clk/32)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
nxt  input  1  1-clk pulse; start the next round-robin conversion
MISO  input  1  serial data from A2D
SS_n  output  1  active-low slave select
SCLK  output  1  serial clock
MOSI  output  1  serial data to A2D
lft_ld  output  12  latest channel-0 result
rght_ld  output  12  latest channel-4 result
batt  output  12  latest channel-5 result
vld  output  1  1-clk pulse when any result register updates

Interface: reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset values:
  - SS_n=1, SCLK=1, MOSI=0.
  - lft_ld, rght_ld, batt = 12'h000; vld=0.
  - Channel pointer = index 0 (channel 0); FSM = IDLE.
- Command word: {2'b00, ch[2:0], 11'h000}.
  - ch0 -> 16'h0000; ch4 -> 16'h2000; ch5 -> 16'h2800.
- Round-robin order: 0 -> 4 -> 5 -> 0.
  - Pointer advances only when a result is stored, never on an aborted conversion.
- FSM states IDLE, CMD, GAP, READ, STORE:
  - IDLE: on nxt, assert wrt to SPI master with the command for the current channel -> CMD.
  - CMD: wait for done. Returned data is discarded -> GAP.
  - GAP: one clk with SS_n high (required inter-frame deselect). Re-issue the same command -> READ.
  - READ: wait for done -> STORE.
  - STORE (one clk):
    - Write rd_data[11:0] into the register selected by the pointer; rd_data[15:12] is ignored.
    - Pulse vld; advance pointer -> IDLE.
- nxt is ignored in every state except IDLE. It is not queued.
- Only the selected result register changes in STORE. The other two hold their values.
- Serial timing, inside the SPI master:
  - Divider counter is held at 5'b10111 while idle; SCLK = counter MSB.
  - SS_n falls the clk after wrt.
  - MOSI shifts, MSB first, when counter==5'b11111 (SCLK about to fall).
  - MISO is sampled when counter==5'b01111 (SCLK about to rise).
  - After 16 samples and the final trailing fall-edge slot: SCLK stays high, SS_n rises, and done pulses for 1 clk.
  - done occurs no later than 16*2^SCLK_DIV_W + 8 clks after wrt.
- Shift register: the same 16-bit register shifts MOSI out and MISO in. rd_data is valid on the done cycle and held until the next wrt.
- Reset mid-transaction:
  - SS_n returns high and SCLK high immediately (async).
  - All results clear; pointer returns to channel 0.
- A wrt to the SPI master while it is busy is ignored (it cannot occur from this FSM).

Decomposition:
- Package a2d_pkg holds:
  - CH_LFT=3'd0, CH_RGHT=3'd4, CH_BATT=3'd5.
  - Command-builder function.
  - FSM state enum.
  - Round-robin index typedef (2 bits, values 0..2).
- One sub-module, spi_mstr16:
  - Ports: clk, rst_n, wrt, cmd[15:0], MISO -> SS_n, SCLK, MOSI, done, rd_data[15:0].
  - Parameterized by SCLK_DIV_W; reusable for other SPI peripherals.
- a2d_intf contains the FSM, channel pointer and result registers.

Test Plan (bench drives the ADC128S model on SPI pins):
1. Channel 0 read: set ld_cell_lft=12'hA5C; pulse nxt.
   - Both frames carry MOSI word 16'h0000.
   - lft_ld=12'hA5C with a single vld pulse within 2*(16*32+8)+4 clks.
   - rght_ld and batt stay 0.
2. Channel 4 read: set ld_cell_rght=12'h3C1; second nxt.
   - MOSI word 16'h2000 in both frames; rght_ld=12'h3C1.
3. Channel 5 read: set batt_V=12'hD80; third nxt.
   - MOSI 16'h2800; batt=12'hD80.
4. Wrap-around: fourth nxt.
   - MOSI returns to 16'h0000 and lft_ld updates.
   - No A2D channel warning is printed in the run.
5. Busy ignore: pulse nxt every 50 clks during a conversion.
   - Exactly one vld per conversion; pointer advances by one.
   - SS_n high for at least 1 clk between frames.
6. Reset mid-frame: assert rst_n low during the 8th SCLK of the READ frame.
   - SS_n=1, SCLK=1 and results=0 without waiting for clk.
   - Next nxt after release sends 16'h0000 (channel 0).
